frame_sched: RTL and testbench
==============================

// Module: frame_sched
// PURPOSE
//  Per-frame scheduler for the 33 MHz framebuffer write path. On each frame_start it clears a band of rows
//  to the background palette, starts the sprite painter, and owns the single write port meanwhile.
//  After the painter finishes it issues the game_tick that advances the runner.
//  Sits between vga (frame_start, write port) and painter/runner (paint_start, finished, tick).
// PARAMETERS
//  SCREEN_W       800  pixels per row; clear x range 0..SCREEN_W-1
//  CLEAR_Y_BEGIN  0    first row cleared each frame
//  CLEAR_Y_END    599  last row cleared (inclusive, >= CLEAR_Y_BEGIN)
//  BG_PALETTE     2'd0 palette index written during clear
//  TICK_DIV       1    frames per game_tick (1..15)
//  PAINT_TIMEOUT  500000 max cycles in PAINT before forced abort
// PORTS
//  clk_33m         in   1   33 MHz clock; single clock domain
//  rst             in   1   synchronous, active-high reset
//  frame_start     in   1   1-cycle pulse, new back buffer available
//  painter_finished in  1   1-cycle pulse, painter done
//  p_write_x       in   12  painter pixel x
//  p_write_y       in   12  painter pixel y
//  p_write_palette in   2   painter palette index
//  p_write_en      in   1   painter write strobe
//  paint_start     out  1   1-cycle pulse, painter may begin
//  write_x         out  12  framebuffer x (registered)
//  write_y         out  12  framebuffer y (registered)
//  write_palette   out  2   framebuffer palette (registered)
//  write_en        out  1   framebuffer write strobe (registered)
//  game_tick       out  1   1-cycle pulse, runner advances one step
//  overrun_count   out  8   frames dropped/late, saturates at 255
//  paint_timeout   out  1   sticky, set on PAINT watchdog abort
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; tick divider 0; overrun_count 0; paint_timeout 0.
//  States: IDLE -> CLEAR -> PAINT -> TICK -> IDLE.
//   IDLE: frame_start -> CLEAR. Load x=0, y=CLEAR_Y_BEGIN.
//   CLEAR: one write per cycle. Raster order: x runs fastest; at x=SCREEN_W-1, x<=0 and y++.
//    On the write of (SCREEN_W-1, CLEAR_Y_END) -> PAINT.
//    Clear takes exactly SCREEN_W*(CLEAR_Y_END-CLEAR_Y_BEGIN+1) cycles.
//   PAINT: paint_start=1 on the first PAINT cycle only. Port passes p_write_* with 1-cycle register latency.
//    painter_finished -> TICK.
//    Watchdog reaches PAINT_TIMEOUT -> set paint_timeout, increment overrun_count, -> TICK.
//   TICK: divider++. When divider==TICK_DIV-1: game_tick=1 for this one cycle, divider<=0. -> IDLE.
//  Latency: frame_start at cycle t -> first clear write visible on write_* at t+1.
//   p_write_* at t -> write_* at t+1.
//  Port ownership: write_en=0 in IDLE and TICK. p_write_en is ignored outside PAINT.
//   No cycle ever carries both a clear write and a painter write.
//  frame_start outside IDLE: the pulse is dropped (no restart, no queue) and overrun_count increments.
//   This also applies when it coincides with painter_finished; the PAINT->TICK transition still happens.
//  frame_start in TICK: dropped and counted; the tick still fires.
//  painter_finished outside PAINT: ignored.
//  Counter widths: x and y 12 bit; watchdog 20 bit; clear never wraps past CLEAR_Y_END.
//  rst mid-CLEAR/PAINT: next cycle IDLE, write_en=0, and no pending tick or paint_start.
// STRUCTURE
//  runner_pkg gains:
//   - typedef enum logic[1:0] {FS_IDLE, FS_CLEAR, FS_PAINT, FS_TICK} frame_sched_state_t
//   - SCREEN_W and SCREEN_H constants, shared with vga/painter
//  Sub-module fb_clear_engine: raster x/y counter with start/done, parameterised on SCREEN_W and the Y range.
//  frame_sched holds the FSM, write-port mux/register, tick divider, watchdog and overrun counter.
// TESTING (bench params SCREEN_W=8, CLEAR_Y_BEGIN=2, CLEAR_Y_END=3, TICK_DIV=2, PAINT_TIMEOUT=40)
//  1. Pulse frame_start -> 16 consecutive write_en cycles, (0,2)..(7,3), palette 0.
//     Then paint_start pulses once on the next cycle.
//  2. In PAINT drive p_write (5,6,pal 3,en) -> write_x=5, write_y=6, palette 3, en=1 one cycle later.
//     The same stimulus in IDLE -> write_en stays 0.
//  3. Two full frames, painter_finished 10 cycles after each paint_start -> game_tick on the 2nd frame only,
//     1 cycle wide.
//  4. frame_start in mid-CLEAR and again in the same cycle as painter_finished -> overrun_count=2.
//     The clear sequence stays uninterrupted.
//  5. Never pulse painter_finished -> after 40 PAINT cycles paint_timeout=1, overrun_count=1, state TICK then IDLE.
//  6. Assert rst at clear write 5 -> write_en=0 next cycle, all outputs 0, and the next frame_start restarts at (0,2).

Source files
------------

// File: rtl/runner_pkg.sv
// Shared definitions for the runner game's video path.
//   frame_sched_state_t : frame scheduler FSM states
//   SCREEN_W / SCREEN_H : visible raster size, shared with vga and painter
package runner_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_CLEAR,
    FS_PAINT,
    FS_TICK
  } frame_sched_state_t;

  localparam int unsigned SCREEN_W = 800;
  localparam int unsigned SCREEN_H = 600;

endpackage

// File: rtl/fb_clear_engine.sv
// Raster coordinate generator for the per-frame background clear.
// x runs fastest over 0..SCREEN_W-1, y over Y_BEGIN..Y_END.
//   clk_33m, rst : clock, synchronous active-high reset
//   start        : begin a new clear pass (clears done)
//   step         : current (x,y) is consumed; advance to the next coordinate
//   x, y         : coordinate to be written when step is asserted
//   last         : current (x,y) is the final coordinate of the band
//   done         : final coordinate has been consumed since the last start
module fb_clear_engine #(
  parameter int unsigned SCREEN_W = runner_pkg::SCREEN_W,
  parameter int unsigned Y_BEGIN  = 0,
  parameter int unsigned Y_END    = runner_pkg::SCREEN_H - 1
) (
  input  logic        clk_33m,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        last,
  output logic        done
);
  import runner_pkg::*;

  localparam logic [11:0] X_LAST  = 12'(SCREEN_W - 1);
  localparam logic [11:0] Y_FIRST = 12'(Y_BEGIN);
  localparam logic [11:0] Y_LAST  = 12'(Y_END);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Counters return to the band origin after the final coordinate, so an
  // idle engine always presents the first coordinate of the next pass.
  always_ff @(posedge clk_33m) begin
    if (rst) begin
      x    <= '0;
      y    <= Y_FIRST;
      done <= 1'b0;
    end else begin
      if (start) begin
        done <= 1'b0;
      end
      if (step) begin
        if (last) begin
          x    <= '0;
          y    <= Y_FIRST;
          done <= 1'b1;
        end else if (x == X_LAST) begin
          x <= '0;
          y <= y + 12'd1;
        end else begin
          x <= x + 12'd1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_sched.sv
// Per-frame scheduler for the framebuffer write path: clears a band of rows
// to the background palette, hands the write port to the sprite painter,
// then issues the game_tick that advances the runner.
//   clk_33m, rst       : clock, synchronous active-high reset
//   frame_start        : new back buffer available (pulse)
//   painter_finished   : painter done (pulse)
//   p_write_*          : painter write request
//   paint_start        : painter may begin (pulse, first PAINT cycle)
//   write_*            : registered framebuffer write port
//   game_tick          : runner advances one step (pulse)
//   overrun_count      : dropped/late frames, saturating at 255
//   paint_timeout      : sticky, painter watchdog fired
module frame_sched #(
  parameter int unsigned SCREEN_W      = runner_pkg::SCREEN_W,
  parameter int unsigned CLEAR_Y_BEGIN = 0,
  parameter int unsigned CLEAR_Y_END   = runner_pkg::SCREEN_H - 1,
  parameter logic [1:0]  BG_PALETTE    = 2'd0,
  parameter int unsigned TICK_DIV      = 1,
  parameter int unsigned PAINT_TIMEOUT = 500000
) (
  input  logic        clk_33m,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        painter_finished,
  input  logic [11:0] p_write_x,
  input  logic [11:0] p_write_y,
  input  logic [1:0]  p_write_palette,
  input  logic        p_write_en,
  output logic        paint_start,
  output logic [11:0] write_x,
  output logic [11:0] write_y,
  output logic [1:0]  write_palette,
  output logic        write_en,
  output logic        game_tick,
  output logic [7:0]  overrun_count,
  output logic        paint_timeout
);
  import runner_pkg::*;

  localparam logic [19:0] WD_LAST  = 20'(PAINT_TIMEOUT - 1);
  localparam logic [3:0]  DIV_LAST = 4'(TICK_DIV - 1);

  frame_sched_state_t state, state_next;

  logic [11:0] clr_x, clr_y;
  logic        clr_last, clr_done, clr_start, clr_step;

  logic [11:0] wr_x_d, wr_y_d;
  logic [1:0]  wr_pal_d;
  logic        wr_en_d;
  logic        wd_abort;
  logic        frame_dropped;
  logic [19:0] watchdog;
  logic [3:0]  tick_div;
  logic [1:0]  overrun_inc;
  logic [8:0]  overrun_sum;

  fb_clear_engine #(
    .SCREEN_W (SCREEN_W),
    .Y_BEGIN  (CLEAR_Y_BEGIN),
    .Y_END    (CLEAR_Y_END)
  ) u_clear (
    .clk_33m (clk_33m),
    .rst     (rst),
    .start   (clr_start),
    .step    (clr_step),
    .x       (clr_x),
    .y       (clr_y),
    .last    (clr_last),
    .done    (clr_done)
  );

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      state <= FS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The write register is loaded one cycle ahead of the state it belongs to:
  // the first clear coordinate is loaded in the IDLE cycle that sees
  // frame_start, and the CLEAR state then spans exactly the visible writes.
  // A painter request arriving in the cycle PAINT is left is dropped so the
  // port stays quiet throughout TICK.
  always_comb begin
    state_next    = state;
    clr_start     = 1'b0;
    clr_step      = 1'b0;
    wr_en_d       = 1'b0;
    wr_x_d        = '0;
    wr_y_d        = '0;
    wr_pal_d      = '0;
    wd_abort      = 1'b0;
    game_tick     = 1'b0;
    frame_dropped = frame_start && (state != FS_IDLE);

    case (state)
      FS_IDLE: begin
        if (frame_start) begin
          state_next = FS_CLEAR;
          clr_start  = 1'b1;
          clr_step   = 1'b1;
          wr_en_d    = 1'b1;
          wr_x_d     = clr_x;
          wr_y_d     = clr_y;
          wr_pal_d   = BG_PALETTE;
        end
      end
      FS_CLEAR: begin
        if (clr_done) begin
          state_next = FS_PAINT;
        end else begin
          clr_step = 1'b1;
          wr_en_d  = 1'b1;
          wr_x_d   = clr_x;
          wr_y_d   = clr_y;
          wr_pal_d = BG_PALETTE;
        end
      end
      FS_PAINT: begin
        if (painter_finished) begin
          state_next = FS_TICK;
        end else if (watchdog == WD_LAST) begin
          state_next = FS_TICK;
          wd_abort   = 1'b1;
        end else begin
          wr_en_d  = p_write_en;
          wr_x_d   = p_write_x;
          wr_y_d   = p_write_y;
          wr_pal_d = p_write_palette;
        end
      end
      FS_TICK: begin
        state_next = FS_IDLE;
        game_tick  = (tick_div == DIV_LAST);
      end
      default: begin
        state_next = FS_IDLE;
      end
    endcase
  end

  assign overrun_inc = {1'b0, frame_dropped} + {1'b0, wd_abort};
  assign overrun_sum = {1'b0, overrun_count} + {7'd0, overrun_inc};

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      write_x       <= '0;
      write_y       <= '0;
      write_palette <= '0;
      write_en      <= 1'b0;
      paint_start   <= 1'b0;
      watchdog      <= '0;
      tick_div      <= '0;
      overrun_count <= '0;
      paint_timeout <= 1'b0;
    end else begin
      write_x       <= wr_x_d;
      write_y       <= wr_y_d;
      write_palette <= wr_pal_d;
      write_en      <= wr_en_d;
      paint_start   <= (state == FS_CLEAR) && clr_done;
      watchdog      <= (state == FS_PAINT) ? watchdog + 20'd1 : '0;
      if (state == FS_TICK) begin
        tick_div <= (tick_div == DIV_LAST) ? '0 : tick_div + 4'd1;
      end
      paint_timeout <= paint_timeout | wd_abort;
      overrun_count <= (overrun_sum > 9'd255) ? 8'hFF : overrun_sum[7:0];
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
module tb_frame_sched;

  localparam int unsigned SW   = 8;
  localparam int unsigned CYB  = 2;
  localparam int unsigned CYE  = 3;
  localparam int unsigned TDIV = 2;
  localparam int unsigned PTO  = 40;
  localparam int unsigned NCLR = SW * (CYE - CYB + 1);

  logic        clk_33m;
  logic        rst;
  logic        frame_start;
  logic        painter_finished;
  logic [11:0] p_write_x;
  logic [11:0] p_write_y;
  logic [1:0]  p_write_palette;
  logic        p_write_en;
  logic        paint_start;
  logic [11:0] write_x;
  logic [11:0] write_y;
  logic [1:0]  write_palette;
  logic        write_en;
  logic        game_tick;
  logic [7:0]  overrun_count;
  logic        paint_timeout;

  frame_sched #(
    .SCREEN_W      (SW),
    .CLEAR_Y_BEGIN (CYB),
    .CLEAR_Y_END   (CYE),
    .BG_PALETTE    (2'd0),
    .TICK_DIV      (TDIV),
    .PAINT_TIMEOUT (PTO)
  ) dut (
    .clk_33m          (clk_33m),
    .rst              (rst),
    .frame_start      (frame_start),
    .painter_finished (painter_finished),
    .p_write_x        (p_write_x),
    .p_write_y        (p_write_y),
    .p_write_palette  (p_write_palette),
    .p_write_en       (p_write_en),
    .paint_start      (paint_start),
    .write_x          (write_x),
    .write_y          (write_y),
    .write_palette    (write_palette),
    .write_en         (write_en),
    .game_tick        (game_tick),
    .overrun_count    (overrun_count),
    .paint_timeout    (paint_timeout)
  );

  initial clk_33m = 1'b0;
  always #15 clk_33m = ~clk_33m;

  int          checks = 0;
  int          errors = 0;
  logic [25:0] exp_q[$];

  // reference model of the externally visible counters
  int unsigned ov_model;
  int unsigned frames_model;
  bit          tm_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_33m);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    ov_model     = 0;
    frames_model = 0;
    tm_model     = 1'b0;
  endtask

  task automatic ov_bump();
    if (ov_model < 255) ov_model++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_write_en"}, 32'(write_en), 32'd0);
    chk({tag, "_write_x"}, 32'(write_x), 32'd0);
    chk({tag, "_write_y"}, 32'(write_y), 32'd0);
    chk({tag, "_write_pal"}, 32'(write_palette), 32'd0);
    chk({tag, "_paint_start"}, 32'(paint_start), 32'd0);
    chk({tag, "_game_tick"}, 32'(game_tick), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun_count), 32'd0);
    chk({tag, "_timeout"}, 32'(paint_timeout), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    step();
    model_reset();
    check_zero(tag);
    rst = 1'b0;
    step();
  endtask

  // Scoreboard monitor: every visible write must match the next expected one.
  always @(negedge clk_33m) begin
    if (write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write actual=(%0d,%0d,%0d) required=none",
                 write_x, write_y, write_palette);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        chk("sb_write", 32'({write_x, write_y, write_palette}), 32'(e));
      end
    end
  end

  task automatic drive_painter(input bit fixed, input bit expect_taken);
    if (fixed) begin
      p_write_x       = 12'd5;
      p_write_y       = 12'd6;
      p_write_palette = 2'd3;
      p_write_en      = 1'b1;
    end else begin
      p_write_x       = 12'($urandom);
      p_write_y       = 12'($urandom);
      p_write_palette = 2'($urandom);
      p_write_en      = 1'($urandom);
    end
    if (p_write_en && expect_taken)
      exp_q.push_back({p_write_x, p_write_y, p_write_palette});
  endtask

  task automatic run_frame(input int unsigned paint_len, input bit drop_clear,
                           input bit drop_finish, input bit drop_tick,
                           input bit timeout, input bit rst_at5);
    for (int unsigned yy = CYB; yy <= CYE; yy++)
      for (int unsigned xx = 0; xx < SW; xx++)
        exp_q.push_back({12'(xx), 12'(yy), 2'd0});
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int unsigned i = 0; i < NCLR; i++) begin
      chk("clear_en", 32'(write_en), 32'd1);
      chk("clear_no_paint_start", 32'(paint_start), 32'd0);
      if (i == 0) begin
        chk("clear_first_x", 32'(write_x), 32'd0);
        chk("clear_first_y", 32'(write_y), 32'(CYB));
      end
      if (rst_at5 && i == 5) begin
        rst = 1'b1;
        step();
        model_reset();
        check_zero("rst_mid_clear");
        rst = 1'b0;
        step();
        check_zero("after_rst");
        return;
      end
      if (drop_clear && i == 5) begin
        frame_start = 1'b1;
        ov_bump();
      end
      step();
      frame_start = 1'b0;
    end
    // first PAINT cycle
    chk("paint_start_pulse", 32'(paint_start), 32'd1);
    chk("paint_first_en", 32'(write_en), 32'd0);
    if (timeout) begin
      for (int unsigned j = 0; j < PTO; j++) begin
        drive_painter(1'b0, j < PTO - 1);
        step();
        if (j == 0) chk("paint_start_once", 32'(paint_start), 32'd0);
        if (j == PTO - 2) chk("timeout_not_early", 32'(paint_timeout), 32'd0);
      end
      p_write_en = 1'b0;
      tm_model = 1'b1;
      ov_bump();
    end else begin
      for (int unsigned j = 0; j < paint_len; j++) begin
        drive_painter(j == 0, 1'b1);
        step();
        if (j == 0) begin
          chk("paint_start_once", 32'(paint_start), 32'd0);
          chk("pw_x", 32'(write_x), 32'd5);
          chk("pw_y", 32'(write_y), 32'd6);
          chk("pw_pal", 32'(write_palette), 32'd3);
          chk("pw_en", 32'(write_en), 32'd1);
        end
      end
      p_write_en = 1'b0;
      painter_finished = 1'b1;
      if (drop_finish) begin
        frame_start = 1'b1;
        ov_bump();
      end
      step();
      painter_finished = 1'b0;
      frame_start = 1'b0;
    end
    // TICK cycle
    frames_model++;
    chk("tick_write_en", 32'(write_en), 32'd0);
    chk("game_tick", 32'(game_tick), 32'((frames_model % TDIV) == 0));
    chk("overrun_count", 32'(overrun_count), 32'(ov_model));
    chk("paint_timeout", 32'(paint_timeout), 32'(tm_model));
    if (drop_tick) begin
      frame_start = 1'b1;
      ov_bump();
    end
    step();
    frame_start = 1'b0;
    // IDLE
    chk("idle_game_tick", 32'(game_tick), 32'd0);
    chk("idle_write_en", 32'(write_en), 32'd0);
    chk("idle_overrun", 32'(overrun_count), 32'(ov_model));
    if (drop_tick) begin
      step();
      chk("tick_drop_no_clear", 32'(write_en), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    painter_finished = 1'b0;
    p_write_x = '0;
    p_write_y = '0;
    p_write_palette = '0;
    p_write_en = 1'b0;
    model_reset();
    step();
    do_reset("reset");

    // painter strobes in IDLE must not reach the port
    for (int k = 0; k < 3; k++) begin
      drive_painter(1'b1, 1'b0);
      painter_finished = 1'b1;
      step();
      chk("idle_pw_ignored", 32'(write_en), 32'd0);
      chk("idle_no_paint_start", 32'(paint_start), 32'd0);
    end
    p_write_en = 1'b0;
    painter_finished = 1'b0;

    run_frame(12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_reset("reset2");
    run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_frame(8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("overrun_two", 32'(overrun_count), 32'd2);
    run_frame(6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 5; r++)
      run_frame($urandom_range(1, 30), 1'($urandom), 1'($urandom),
                1'($urandom), 1'b0, 1'b0);

    run_frame(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
